// File: rtl/ines_pkg.sv
// Shared types and constants for the iNES cartridge-image loader.
package ines_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        TRAIN,
        PRG,
        CHR,
        DONE,
        ERROR
    } state_e;

    localparam int HDR_LEN   = 16;
    localparam int TRAIN_LEN = 512;
    localparam int PRG_BANK  = 16384;
    localparam int CHR_BANK  = 8192;
    localparam int MAX_PRG   = 16;
    localparam int MAX_CHR   = 8;
    localparam int CNT_W     = 18;

    localparam logic [31:0] MAGIC = 32'h4E45_531A;

    typedef struct packed {
        logic [7:0] num;
        logic [3:0] max_bank;
        logic       mirror;
        logic       chr_ram;
    } hdr_info_t;

    function automatic logic [7:0] magic_byte(input logic [1:0] idx);
        return MAGIC[8*(3-int'(idx)) +: 8];
    endfunction

endpackage

// File: rtl/ines_header_parser.sv
// Captures the 16-byte iNES header one byte at a time and flags bad images.
module ines_header_parser
    import ines_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       clear_i,
    input  logic       byte_v_i,
    input  logic [3:0] idx_i,
    input  logic [7:0] byte_i,
    output hdr_info_t  info_o,
    output logic [4:0] prg_cnt_o,
    output logic [3:0] chr_cnt_o,
    output logic       trainer_o,
    output logic       ok_o,
    output logic       error_o
);

    logic [7:0] prg_q, chr_q, flags6_q, flags7_q;
    hdr_info_t  info_q;
    logic       magic_bad, size_bad, last_byte;

    assign last_byte = (idx_i == 4'(HDR_LEN - 1));
    assign magic_bad = (idx_i < 4'd4) && (byte_i != magic_byte(idx_i[1:0]));
    // Size limits are only judged once the whole header is in.
    assign size_bad  = last_byte && ((prg_q == 8'd0) || (prg_q > 8'(MAX_PRG)) ||
                                     (chr_q > 8'(MAX_CHR)));

    assign error_o   = byte_v_i && (magic_bad || size_bad);
    assign ok_o      = byte_v_i && last_byte && !size_bad;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prg_q    <= '0;
            chr_q    <= '0;
            flags6_q <= '0;
            flags7_q <= '0;
            info_q   <= '0;
        end else if (clear_i) begin
            prg_q    <= '0;
            chr_q    <= '0;
            flags6_q <= '0;
            flags7_q <= '0;
            info_q   <= '0;
        end else if (byte_v_i) begin
            unique case (idx_i)
                4'd4:    prg_q    <= byte_i;
                4'd5:    chr_q    <= byte_i;
                4'd6:    flags6_q <= byte_i;
                4'd7:    flags7_q <= byte_i;
                default: ;
            endcase
            if (ok_o) begin
                info_q.num      <= {flags7_q[7:4], flags6_q[7:4]};
                info_q.max_bank <= prg_q[3:0] - 4'd1;
                info_q.mirror   <= flags6_q[0];
                info_q.chr_ram  <= (chr_q == 8'd0);
            end
        end
    end

    assign info_o    = info_q;
    assign prg_cnt_o = prg_q[4:0];
    assign chr_cnt_o = chr_q[3:0];
    assign trainer_o = flags6_q[2];

endmodule

// File: rtl/ines_loader.sv
// iNES image loader: parses the header, skips the trainer, and streams PRG/CHR
// payload into cartridge SRAM while holding the console in reset.
module ines_loader
    import ines_pkg::*;
#(
    parameter  int PRG_AW = 18,
    parameter  int CHR_AW = 16,
    localparam int MEM_AW = (PRG_AW > CHR_AW) ? PRG_AW : CHR_AW
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        in_d,
    input  logic              in_v,
    output logic              in_r,
    input  logic              mem_busy,
    output logic [MEM_AW-1:0] mem_a,
    output logic [7:0]        mem_o,
    output logic              mem_w,
    output logic              mem_chr,
    output logic [7:0]        num,
    output logic [3:0]        max,
    output logic              mirror,
    output logic              chr_ram,
    output logic              done,
    output logic              error
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W:0]    cnt_inc, prg_len, chr_len;
    logic              accept, enter_hdr, hdr_v, wr_take, sect_last;

    logic [MEM_AW-1:0] mem_a_q;
    logic [7:0]        mem_o_q;
    logic              mem_w_q, mem_chr_q;

    hdr_info_t         info;
    logic [4:0]        prg_cnt;
    logic [3:0]        chr_cnt;
    logic              trainer, hdr_ok, hdr_err;

    // A stalled write keeps mem_busy high, so gating on busy also covers it.
    always_comb begin
        in_r = 1'b0;
        unique case (state_q)
            HDR, TRAIN, PRG, CHR: in_r = !mem_busy && !start;
            ERROR:                in_r = !start;
            default:              in_r = 1'b0;
        endcase
    end

    assign accept    = in_v && in_r;
    assign enter_hdr = start || (state_q == IDLE);
    assign hdr_v     = accept && (state_q == HDR);
    assign wr_take   = accept && ((state_q == PRG) || (state_q == CHR));

    assign cnt_inc   = {1'b0, cnt_q} + (CNT_W+1)'(1);
    assign prg_len   = (CNT_W+1)'(prg_cnt) * (CNT_W+1)'(PRG_BANK);
    assign chr_len   = (CNT_W+1)'(chr_cnt) * (CNT_W+1)'(CHR_BANK);
    assign sect_last = (state_q == CHR) ? (cnt_inc == chr_len) : (cnt_inc == prg_len);

    ines_header_parser u_parser (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear_i   (enter_hdr),
        .byte_v_i  (hdr_v),
        .idx_i     (cnt_q[3:0]),
        .byte_i    (in_d),
        .info_o    (info),
        .prg_cnt_o (prg_cnt),
        .chr_cnt_o (chr_cnt),
        .trainer_o (trainer),
        .ok_o      (hdr_ok),
        .error_o   (hdr_err)
    );

    // NOTE: every output of this block gets a default first; a path that left
    // one unassigned would infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: state_d = HDR;
            HDR: if (accept) begin
                if (hdr_err) begin
                    state_d = ERROR;
                end else if (hdr_ok) begin
                    state_d = trainer ? TRAIN : PRG;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc[CNT_W-1:0];
                end
            end
            TRAIN: if (accept) begin
                if (cnt_q == CNT_W'(TRAIN_LEN - 1)) begin
                    state_d = PRG;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc[CNT_W-1:0];
                end
            end
            PRG: if (accept) begin
                if (sect_last) begin
                    state_d = (chr_cnt != 4'd0) ? CHR : DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc[CNT_W-1:0];
                end
            end
            CHR: if (accept) begin
                if (sect_last) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc[CNT_W-1:0];
                end
            end
            default: ;
        endcase
        if (enter_hdr) begin
            state_d = HDR;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Holding register: the accepted byte is presented one cycle later and
    // stays put while the SRAM reports busy; start discards it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_w_q   <= 1'b0;
            mem_a_q   <= '0;
            mem_o_q   <= '0;
            mem_chr_q <= 1'b0;
        end else if (enter_hdr) begin
            mem_w_q   <= 1'b0;
            mem_a_q   <= '0;
        end else if (wr_take) begin
            mem_w_q   <= 1'b1;
            mem_a_q   <= MEM_AW'(cnt_q);
            mem_o_q   <= in_d;
            mem_chr_q <= (state_q == CHR);
        end else if (!mem_busy) begin
            mem_w_q   <= 1'b0;
        end
    end

    assign mem_w   = mem_w_q;
    assign mem_a   = mem_a_q;
    assign mem_o   = mem_o_q;
    assign mem_chr = mem_chr_q;

    assign num     = info.num;
    assign max     = info.max_bank;
    assign mirror  = info.mirror;
    assign chr_ram = info.chr_ram;

    // Hold done low until the final payload write has actually left.
    assign done    = (state_q == DONE) && !mem_w_q;
    assign error   = (state_q == ERROR);

endmodule

// File: tb/tb_ines_loader.sv
// Randomized bench for ines_loader: builds iNES images, predicts the SRAM
// write list and header outputs, and compares every retired write.
module tb_ines_loader;

    localparam int PRG_AW = 18;
    localparam int CHR_AW = 16;
    localparam int AW     = 18;
    localparam int BIG    = 1000000;

    logic          clock = 1'b0;
    logic          reset_n, start, in_v, in_r, mem_busy;
    logic [7:0]    in_d, mem_o, num;
    logic [AW-1:0] mem_a;
    logic [3:0]    max;
    logic          mem_w, mem_chr, mirror, chr_ram, done, error;

    ines_loader #(.PRG_AW(PRG_AW), .CHR_AW(CHR_AW)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .in_d     (in_d),
        .in_v     (in_v),
        .in_r     (in_r),
        .mem_busy (mem_busy),
        .mem_a    (mem_a),
        .mem_o    (mem_o),
        .mem_w    (mem_w),
        .mem_chr  (mem_chr),
        .num      (num),
        .max      (max),
        .mirror   (mirror),
        .chr_ram  (chr_ram),
        .done     (done),
        .error    (error)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [7:0]  src_q[$];
    logic [26:0] wr_q[$];
    int          n_consumed, gap_pct, busy_pct, err_at;
    bit          busy_force, exp_error, hdr_ok, info_chk, err_chk, pre_chk, held_v;
    logic [26:0] held;
    logic [7:0]  exp_num;
    logic [3:0]  exp_max;
    logic        exp_mirror, exp_chr_ram;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Image = header + optional 512-byte trainer + P*16K PRG + C*8K CHR, then junk.
    task automatic build(input logic [7:0] f6, input logic [7:0] f7, input logic [7:0] p,
                         input logic [7:0] c, input logic [7:0] magic2,
                         input int limit, input int junk);
        int n_train, n_prg, n_chr, n;
        logic [7:0] b;
        src_q.delete();
        wr_q.delete();
        n_consumed = 0;
        held_v = 0; info_chk = 0; err_chk = 0; pre_chk = 0;
        src_q.push_back(8'h4E); src_q.push_back(8'h45);
        src_q.push_back(magic2); src_q.push_back(8'h1A);
        src_q.push_back(p); src_q.push_back(c);
        src_q.push_back(f6); src_q.push_back(f7);
        for (int i = 0; i < 8; i++) src_q.push_back(8'($urandom));
        exp_num     = {f7[7:4], f6[7:4]};
        exp_max     = (p == 8'd16) ? 4'd15 : 4'(p - 8'd1);
        exp_mirror  = f6[0];
        exp_chr_ram = (c == 8'd0);
        hdr_ok      = (magic2 == 8'h53) && (p != 0) && (p <= 16) && (c <= 8);
        exp_error   = !hdr_ok;
        err_at      = (magic2 != 8'h53) ? 2 : (hdr_ok ? -10 : 15);
        if (hdr_ok) begin
            n_train = f6[2] ? 512 : 0;
            n_prg   = int'(p) * 16384;
            n_chr   = int'(c) * 8192;
            n = 0;
            for (int i = 0; i < n_train && n < limit; i++) begin
                src_q.push_back(8'($urandom)); n++;
            end
            for (int i = 0; i < n_prg && n < limit; i++) begin
                b = 8'($urandom);
                src_q.push_back(b);
                wr_q.push_back({1'b0, 18'(i), b}); n++;
            end
            for (int i = 0; i < n_chr && n < limit; i++) begin
                b = 8'($urandom);
                src_q.push_back(b);
                wr_q.push_back({1'b1, 18'(i), b}); n++;
            end
        end
        for (int i = 0; i < junk; i++) src_q.push_back(8'($urandom));
    endtask

    task automatic cycle();
        logic [26:0] cur;
        @(negedge clock);
        start    = 1'b0;
        in_v     = (src_q.size() > 0) && ($urandom_range(99) >= gap_pct);
        in_d     = 8'($urandom);
        if (in_v) in_d = src_q[0];
        mem_busy = busy_force || ($urandom_range(99) < busy_pct);
        #1;
        if (info_chk) begin
            check("hdr_num", num, exp_num);
            check("hdr_max", max, exp_max);
            check("hdr_mirror", mirror, exp_mirror);
            check("hdr_chr_ram", chr_ram, exp_chr_ram);
            info_chk = 0;
        end
        if (pre_chk) begin check("error_early", error, 0); pre_chk = 0; end
        if (err_chk) begin check("error_rise", error, 1); err_chk = 0; end
        cur = {mem_chr, mem_a, mem_o};
        if (held_v) check("busy_hold", {mem_w, cur}, {1'b1, held});
        held_v = 0;
        if (mem_w && mem_busy) begin held = cur; held_v = 1; end
        if (mem_w && !mem_busy) begin
            check("write_expected", wr_q.size() > 0, 1);
            if (wr_q.size() > 0) check("write", cur, wr_q.pop_front());
        end
        if (mem_busy && !exp_error) check("in_r_busy", in_r, 0);
        if (in_v && in_r) begin
            void'(src_q.pop_front());
            if (hdr_ok && n_consumed == 15) info_chk = 1;
            if (n_consumed == err_at - 1) pre_chk = 1;
            if (n_consumed == err_at) err_chk = 1;
            n_consumed++;
        end
    endtask

    task automatic run_to_done(input int budget, input int extra);
        int g = 0;
        while (done !== 1'b1 && g < budget) begin cycle(); g++; end
        check("done_reached", done, 1);
        check("writes_left", wr_q.size(), 0);
        check("no_error", error, 0);
        repeat (6) cycle();
        check("extra_kept", src_q.size(), extra);
        check("done_hold", done, 1);
    endtask

    task automatic run_drain(input int budget);
        int g = 0;
        while (src_q.size() > 0 && g < budget) begin cycle(); g++; end
        check("drained", src_q.size(), 0);
        check("error_sticky", error, 1);
        check("error_done_low", done, 0);
    endtask

    task automatic run_until(input int n, input int budget);
        int g = 0;
        while (n_consumed < n && g < budget) begin cycle(); g++; end
        check("progress", n_consumed >= n, 1);
    endtask

    task automatic pulse_start(input bit busy);
        @(negedge clock);
        start = 1'b1; in_v = 1'b0; mem_busy = busy;
        #1;
        if (busy) check("drop_pending", mem_w, 1);
        @(negedge clock);
        start = 1'b0; mem_busy = 1'b0;
        #1;
        check("start_no_write", mem_w, 0);
        check("start_flags", {done, error}, 0);
        check("start_hdr_regs", {num, max, mirror, chr_ram}, 0);
        check("start_in_r", in_r, 1);
        held_v = 0;
    endtask

    task automatic do_reset();
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_ctrl", {in_r, mem_w, mem_chr, done, error}, 0);
        check("arst_addr", mem_a, 0);
        check("arst_data", mem_o, 0);
        check("arst_hdr", {num, max, mirror, chr_ram}, 0);
        @(negedge clock);
        in_v = 1'b0; mem_busy = 1'b0; start = 1'b0;
        reset_n = 1'b1;
        #1;
        check("idle_in_r", in_r, 0);
        @(negedge clock);
        #1;
        check("hdr_in_r", in_r, 1);
        held_v = 0;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b1; start = 1'b0; in_v = 1'b0; in_d = 8'h00; mem_busy = 1'b0;
        busy_force = 0; gap_pct = 0; busy_pct = 0; exp_error = 0; hdr_ok = 0;
        err_at = -10; n_consumed = 0;
        do_reset();

        // Bad magic (byte 2 = 54): error on the next cycle, never a write.
        gap_pct = 20; busy_pct = 10;
        build(8'h01, 8'h00, 8'd1, 8'd1, 8'h54, 0, 12);
        run_drain(2000);
        pulse_start(0);

        // Valid image P=1 C=1, vertical mirroring, random gaps and stalls.
        gap_pct = 10; busy_pct = 5;
        build(8'h01, 8'h00, 8'd1, 8'd1, 8'h53, BIG, 4);
        run_to_done(60000, 4);
        pulse_start(0);

        // Mapper 2 with trainer, CHR RAM: PRG only, trainer bytes never written.
        gap_pct = 0; busy_pct = 15;
        build(8'h24, 8'h00, 8'd1, 8'd0, 8'h53, BIG, 3);
        run_to_done(40000, 3);
        pulse_start(0);

        // P=17 and C=9 are rejected at byte 15.
        gap_pct = 10; busy_pct = 10;
        build(8'h00, 8'h00, 8'd17, 8'd0, 8'h53, 0, 6);
        run_drain(2000);
        pulse_start(0);
        build(8'h00, 8'h00, 8'd1, 8'd9, 8'h53, 0, 6);
        run_drain(2000);
        pulse_start(0);

        // P=16 accepted (max=15); directed 3-cycle stall, then start mid-PRG.
        gap_pct = 0; busy_pct = 0;
        build(8'h31, 8'hA0, 8'd16, 8'd0, 8'h53, 300, 0);
        run_until(76, 1000);
        busy_force = 1;
        repeat (3) cycle();
        busy_force = 0;
        repeat (2) cycle();
        run_until(150, 1000);
        pulse_start(1);

        // Asynchronous reset in the middle of PRG.
        gap_pct = 5; busy_pct = 5;
        build(8'h01, 8'h00, 8'd1, 8'd0, 8'h53, 200, 0);
        run_until(56, 1000);
        do_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
